// File: rtl/mz_memctl_gen2.sv
// MZ-80B/MZ-2000 second-generation memory controller: DRAM bank decode through
// a writable window map, IPL ROM select, ROM wait states and GRAM blank-wait.
module mz_memctl_gen2 #(
    parameter int unsigned NBANKS       = 4,
    parameter int unsigned ROM_WAIT     = 1,
    parameter int unsigned GRAM_TIMEOUT = 0,
    parameter logic [7:0]  MAP_PORT     = 8'hB8
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              nMREQ,
    input  logic              nRFSH,
    input  logic              nRD,
    input  logic              nWR,
    input  logic              nIORQ,
    input  logic              nM1,
    input  logic [3:0]        AD,
    input  logic [7:0]        IOA,
    input  logic [7:0]        D,
    input  logic              nMRAM,
    input  logic              GRAM_SEL,
    input  logic              BLANK,
    input  logic              nEXWAIT,
    output logic [NBANKS-1:0] nRAS,
    output logic              nROMCS,
    output logic              nCSG,
    output logic              nWAIT,
    output logic              fastLCSW,
    output logic              BUFG0,
    output logic              BUFGM,
    output logic              TOUT_ERR
);

    localparam int unsigned BB    = $clog2(NBANKS);
    localparam int unsigned GW    = (GRAM_TIMEOUT > 1) ? $clog2(GRAM_TIMEOUT) : 1;
    localparam int unsigned TLAST = (GRAM_TIMEOUT > 0) ? GRAM_TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {
        G_IDLE  = 2'd0,
        G_WAITB = 2'd1,
        G_GRANT = 2'd2,
        G_TOUT  = 2'd3
    } gstate_e;

    logic                  mreq;
    logic                  rfsh;
    logic [1:0]            win;
    logic                  map_wr;
    logic                  gram_req;
    logic                  rom_hold;
    logic                  gram_hold;
    logic                  bank_vld;
    logic [BB-1:0]         bank;

    logic [3:0][BB-1:0]    map_q, map_d;
    logic                  wr_seen_q, wr_seen_d;
    logic [2:0]            rcnt_q, rcnt_d;
    gstate_e               state_q, state_d;
    logic [GW-1:0]         gcnt_q, gcnt_d;
    logic                  tout_err_q, tout_err_d;
    logic                  unused_ok;

    assign mreq      = ~nMREQ & nRFSH;
    assign rfsh      = ~nMREQ & ~nRFSH;
    assign win       = AD[3:2];
    assign gram_req  = mreq & GRAM_SEL;
    assign map_wr    = ~nIORQ & ~nWR & nM1 & (IOA == MAP_PORT) & ~wr_seen_q;
    assign unused_ok = ^{D[5:0], AD[1:0]};

    // Window-map update: one write per I/O cycle, re-armed when IORQ goes high
    always_comb begin
        map_d     = map_q;
        wr_seen_d = wr_seen_q;
        if (nIORQ) begin
            wr_seen_d = 1'b0;
        end else if (map_wr) begin
            map_d[D[7:6]] = D[BB-1:0];
            wr_seen_d     = 1'b1;
        end
    end

    // ROM wait counter: cycles since MREQ went low, saturating at 7
    always_comb begin
        rcnt_d = rcnt_q;
        if (nMREQ) begin
            rcnt_d = 3'd0;
        end else if (rcnt_q != 3'd7) begin
            rcnt_d = rcnt_q + 3'd1;
        end
    end

    // GRAM arbitration next state; MREQ release returns to idle from anywhere
    always_comb begin
        state_d    = state_q;
        gcnt_d     = '0;
        tout_err_d = tout_err_q;
        if (nMREQ) begin
            state_d = G_IDLE;
        end else begin
            case (state_q)
                G_IDLE: begin
                    if (gram_req) begin
                        state_d = BLANK ? G_GRANT : G_WAITB;
                    end
                end
                G_WAITB: begin
                    if (BLANK) begin
                        state_d = G_GRANT;
                    end else if ((GRAM_TIMEOUT > 0) && (gcnt_q == GW'(TLAST))) begin
                        state_d    = G_TOUT;
                        tout_err_d = 1'b1;
                    end else begin
                        gcnt_d = gcnt_q + GW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int w = 0; w < 4; w++) begin
                map_q[w] <= BB'(w % NBANKS);
            end
            wr_seen_q  <= 1'b0;
            rcnt_q     <= 3'd0;
            state_q    <= G_IDLE;
            gcnt_q     <= '0;
            tout_err_q <= 1'b0;
        end else begin
            map_q      <= map_d;
            wr_seen_q  <= wr_seen_d;
            rcnt_q     <= rcnt_d;
            state_q    <= state_d;
            gcnt_q     <= gcnt_d;
            tout_err_q <= tout_err_d;
        end
    end

    // Bank decode: IPL mode hard-wires the upper windows, all-RAM uses the map
    always_comb begin
        bank_vld = 1'b1;
        bank     = map_q[win];
        if (nMRAM) begin
            bank_vld = win[1];
            bank     = BB'(win[0]);
        end
    end

    // Per-bank RAS strobes; refresh hits every bank
    always_comb begin
        nRAS = '1;
        for (int b = 0; b < NBANKS; b++) begin
            if (rfsh | (mreq & bank_vld & (bank == BB'(b)))) begin
                nRAS[b] = 1'b0;
            end
        end
    end

    assign nROMCS    = ~(nMRAM & ~win[1] & mreq & ~nRD);
    assign rom_hold  = ~nROMCS & (rcnt_q <= 3'(ROM_WAIT));
    assign nCSG      = ~(gram_req & (BLANK | (state_q == G_GRANT)) & (state_q != G_TOUT));
    assign gram_hold = gram_req & ~BLANK & (state_q != G_GRANT) & (state_q != G_TOUT);
    assign nWAIT     = nEXWAIT & ~rom_hold & ~gram_hold;
    assign fastLCSW  = nRFSH & ~(&nRAS);
    assign BUFG0     = nRD & (nM1 | nIORQ);
    assign BUFGM     = nRD | ~nIORQ;
    assign TOUT_ERR  = tout_err_q;

endmodule

// File: tb/tb_mz_memctl_gen2.sv
// Bench for mz_memctl_gen2: behavioural model plus directed bus cycles.
module tb_mz_memctl_gen2;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       nMREQ = 1'b1, nRFSH = 1'b1, nRD = 1'b1, nWR = 1'b1;
    logic       nIORQ = 1'b1, nM1 = 1'b1;
    logic [3:0] AD = 4'h0;
    logic [7:0] IOA = 8'h00;
    logic [7:0] D = 8'h00;
    logic       nMRAM = 1'b1, GRAM_SEL = 1'b0, BLANK = 1'b0, nEXWAIT = 1'b1;
    logic [3:0] nRAS;
    logic       nROMCS, nCSG, nWAIT, fastLCSW, BUFG0, BUFGM, TOUT_ERR;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    mz_memctl_gen2 #(
        .NBANKS(4), .ROM_WAIT(2), .GRAM_TIMEOUT(8), .MAP_PORT(8'hB8)
    ) dut (
        .CLK(CLK), .nRST(nRST), .nMREQ(nMREQ), .nRFSH(nRFSH), .nRD(nRD),
        .nWR(nWR), .nIORQ(nIORQ), .nM1(nM1), .AD(AD), .IOA(IOA), .D(D),
        .nMRAM(nMRAM), .GRAM_SEL(GRAM_SEL), .BLANK(BLANK), .nEXWAIT(nEXWAIT),
        .nRAS(nRAS), .nROMCS(nROMCS), .nCSG(nCSG), .nWAIT(nWAIT),
        .fastLCSW(fastLCSW), .BUFG0(BUFG0), .BUFGM(BUFGM), .TOUT_ERR(TOUT_ERR)
    );

    always #5 CLK = ~CLK;

    // Model state: bank per window, ROM cycle age, GRAM wait progress
    int m_map [4] = '{0, 1, 2, 3};
    bit m_wr_done = 1'b0;
    int m_age     = 0;
    bit m_waiting = 1'b0, m_granted = 1'b0, m_timedout = 1'b0, m_err = 1'b0;
    int m_wclks   = 0;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_map     <= '{0, 1, 2, 3};
            m_wr_done <= 1'b0;
            m_age     <= 0;
            m_waiting <= 1'b0;
            m_granted <= 1'b0;
            m_timedout <= 1'b0;
            m_wclks   <= 0;
            m_err     <= 1'b0;
        end else begin
            if (nIORQ) m_wr_done <= 1'b0;
            else if (!nWR && nM1 && IOA == 8'hB8 && !m_wr_done) begin
                m_map[int'(D[7:6])] <= int'(D) % 4;
                m_wr_done <= 1'b1;
            end
            m_age <= nMREQ ? 0 : ((m_age + 1 > 7) ? 7 : m_age + 1);
            if (nMREQ) begin
                m_waiting <= 1'b0; m_granted <= 1'b0; m_timedout <= 1'b0; m_wclks <= 0;
            end else if (!m_granted && !m_timedout) begin
                if (m_waiting) begin
                    if (BLANK) begin
                        m_granted <= 1'b1; m_waiting <= 1'b0;
                    end else if (m_wclks + 1 == 8) begin
                        m_timedout <= 1'b1; m_waiting <= 1'b0; m_err <= 1'b1;
                    end else begin
                        m_wclks <= m_wclks + 1;
                    end
                end else if (nRFSH && GRAM_SEL) begin
                    if (BLANK) m_granted <= 1'b1;
                    else begin m_waiting <= 1'b1; m_wclks <= 0; end
                end
            end
        end
    end

    function automatic bit f_mreq();
        return !nMREQ && nRFSH;
    endfunction

    function automatic bit f_rom_page();
        return nMRAM && (int'(AD) < 8);
    endfunction

    function automatic logic [3:0] f_nras();
        logic [3:0] r;
        int bank;
        r = 4'hF;
        bank = nMRAM ? (int'(AD) / 4 - 2) : m_map[int'(AD) / 4];
        if (!nMREQ && !nRFSH) r = 4'h0;
        else if (f_mreq() && !f_rom_page()) r[bank] = 1'b0;
        return r;
    endfunction

    function automatic bit f_nromcs();
        return !(f_mreq() && !nRD && f_rom_page());
    endfunction

    function automatic bit f_ncsg();
        return !(f_mreq() && GRAM_SEL && !m_timedout && (BLANK || m_granted));
    endfunction

    function automatic bit f_nwait();
        bit rom_h, gram_h;
        rom_h  = !f_nromcs() && (m_age <= 2);
        gram_h = f_mreq() && GRAM_SEL && !BLANK && !m_granted && !m_timedout;
        return nEXWAIT && !rom_h && !gram_h;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison against the model, mid-cycle
    always @(negedge CLK) begin
        if (chk_en) begin
            check("m_nRAS",     8'(nRAS),     8'(f_nras()));
            check("m_nROMCS",   8'(nROMCS),   8'(f_nromcs()));
            check("m_nCSG",     8'(nCSG),     8'(f_ncsg()));
            check("m_nWAIT",    8'(nWAIT),    8'(f_nwait()));
            check("m_fastLCSW", 8'(fastLCSW), 8'(nRFSH && (f_nras() != 4'hF)));
            check("m_BUFG0",    8'(BUFG0),    8'(nRD && (nM1 || nIORQ)));
            check("m_BUFGM",    8'(BUFGM),    8'(nRD || !nIORQ));
            check("m_TOUT_ERR", 8'(TOUT_ERR), 8'(m_err));
        end
    end

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic bus_idle();
        nMREQ = 1'b1; nRFSH = 1'b1; nRD = 1'b1; nWR = 1'b1; nIORQ = 1'b1; nM1 = 1'b1;
        GRAM_SEL = 1'b0; BLANK = 1'b0;
    endtask

    task automatic mem_read(input logic [3:0] a, input logic [3:0] exp_ras, input string name);
        next(); AD = a; nMREQ = 1'b0; nRD = 1'b0;
        mid(); check(name, 8'(nRAS), 8'(exp_ras));
        next(); bus_idle();
    endtask

    task automatic io_write(input logic [7:0] port, input logic [7:0] data);
        next(); IOA = port; D = data; nIORQ = 1'b0; nWR = 1'b0;
        next(); D = 8'h00;
        next(); next(); bus_idle();
    endtask

    initial begin
        logic [2:0] rom_wait_exp;
        rom_wait_exp = 3'b100;

        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        chk_en = 1'b1;
        mid();
        check("rst_nRAS",     8'(nRAS),     8'h0F);
        check("rst_nWAIT",    8'(nWAIT),    8'h01);
        check("rst_nCSG",     8'(nCSG),     8'h01);
        check("rst_TOUT_ERR", 8'(TOUT_ERR), 8'h00);
        check("rst_fastLCSW", 8'(fastLCSW), 8'h00);

        // IPL ROM read of 0x1000: two wait states then release
        next(); AD = 4'h1; nMREQ = 1'b0; nRD = 1'b0;
        mid();
        check("rom_nROMCS", 8'(nROMCS), 8'h00);
        check("rom_nRAS",   8'(nRAS),   8'h0F);
        for (int i = 0; i < 3; i++) begin
            next(); mid();
            check("rom_nWAIT", 8'(nWAIT), 8'(rom_wait_exp[i]));
        end
        next(); bus_idle();

        // IPL mode: upper windows fixed to banks 0 and 1
        mem_read(4'h8, 4'b1110, "ipl_w2_nRAS");
        mem_read(4'hC, 4'b1101, "ipl_w3_nRAS");

        // All-RAM mode with map writes; data change mid-cycle must be ignored
        nMRAM = 1'b0;
        io_write(8'hB8, 8'h43);
        io_write(8'hB9, 8'h80);
        io_write(8'hB8, 8'hC5);
        mem_read(4'h5, 4'b0111, "ram_w1_nRAS");
        mem_read(4'h0, 4'b1110, "ram_w0_nRAS");
        mem_read(4'h9, 4'b1011, "ram_w2_nRAS");
        mem_read(4'hF, 4'b1101, "ram_w3_nRAS");

        // Refresh strobes every bank
        next(); nMREQ = 1'b0; nRFSH = 1'b0;
        mid();
        check("rfsh_nRAS",     8'(nRAS),     8'h00);
        check("rfsh_fastLCSW", 8'(fastLCSW), 8'h00);
        check("rfsh_nWAIT",    8'(nWAIT),    8'h01);
        next(); bus_idle();

        // GRAM: wait 5 clocks for blanking, grant survives BLANK falling
        next(); AD = 4'hD; nMREQ = 1'b0; nRD = 1'b0; GRAM_SEL = 1'b1; BLANK = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mid(); check("gram_wait_nWAIT", 8'(nWAIT), 8'h00);
            check("gram_wait_nCSG", 8'(nCSG), 8'h01);
            next();
        end
        BLANK = 1'b1;
        mid(); check("gram_blank_nCSG", 8'(nCSG), 8'h00);
        check("gram_blank_nWAIT", 8'(nWAIT), 8'h01);
        next(); BLANK = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mid(); check("gram_hold_nCSG", 8'(nCSG), 8'h00);
            next();
        end
        bus_idle();
        mid(); check("gram_end_nCSG", 8'(nCSG), 8'h01);

        // GRAM timeout after 8 clocks in the wait state
        next(); AD = 4'hD; nMREQ = 1'b0; nRD = 1'b0; GRAM_SEL = 1'b1; BLANK = 1'b0;
        for (int i = 0; i < 9; i++) begin
            mid(); check("tout_wait_nWAIT", 8'(nWAIT), 8'h00);
            next();
        end
        mid();
        check("tout_nWAIT",    8'(nWAIT),    8'h01);
        check("tout_nCSG",     8'(nCSG),     8'h01);
        check("tout_TOUT_ERR", 8'(TOUT_ERR), 8'h01);
        next(); BLANK = 1'b1;
        mid(); check("tout_blank_nCSG", 8'(nCSG), 8'h01);
        next(); bus_idle();
        mid(); check("tout_sticky", 8'(TOUT_ERR), 8'h01);
        next(); nEXWAIT = 1'b0;
        mid(); check("exwait_nWAIT", 8'(nWAIT), 8'h00);
        next(); nEXWAIT = 1'b1;

        // Reset during a GRAM wait: flag clears, hold stays combinational
        next(); AD = 4'hD; nMREQ = 1'b0; nRD = 1'b0; GRAM_SEL = 1'b1; BLANK = 1'b0;
        next(); next();
        mid(); #2 nRST = 1'b0;
        #1;
        check("rstmid_TOUT_ERR", 8'(TOUT_ERR), 8'h00);
        check("rstmid_nWAIT",    8'(nWAIT),    8'h00);
        next(); nRST = 1'b1;
        next(); bus_idle();
        next(); next();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mz_memctl_gen2.md
Name: mz_memctl_gen2

Overview:
Parametrised second-generation memory controller for the MZ-80B/MZ-2000 board. It decodes Z80 memory cycles into NBANKS DRAM RAS strobes through a runtime-writable window map, and selects the IPL ROM. It generates clocked ROM wait states and GRAM blank-wait with a latched grant and an optional timeout. It sits between the Z80 bus and the DRAM/ROM/GRAM chip selects.

Parameters:
NBANKS, 4, number of 16K DRAM banks; power of two, 2..8; BB = log2(NBANKS).
ROM_WAIT, 1, ROM access is held while rcnt <= ROM_WAIT, giving ROM_WAIT Tw states; range 0..6.
GRAM_TIMEOUT, 0, maximum clocks of GRAM wait; 0 means wait indefinitely.
MAP_PORT, 8'hB8, I/O port address of the window-map register.

Ports:
CLK  in  1  4MHz CPU clock; all state changes on the rising edge.
nRST  in  1  asynchronous active-low reset.
nMREQ, nRFSH, nRD, nWR, nIORQ, nM1  in  1 each  Z80 control signals.
AD  in  4  A15..A12.
IOA  in  8  A7..A0, used for I/O decode.
D  in  8  data bus, used for map writes.
nMRAM  in  1  H = IPL mode, L = all-RAM mode.
GRAM_SEL  in  1  externally decoded GRAM request, active high.
BLANK  in  1  H = display blanking; GRAM is free.
nEXWAIT  in  1  external wait request.
nRAS  out  NBANKS  per-bank RAS, active low.
nROMCS  out  1  IPL ROM select.
nCSG  out  1  GRAM chip select.
nWAIT  out  1  Z80 WAIT.
fastLCSW  out  1  row/column mux enable; the external delay line is unchanged.
BUFG0, BUFGM  out  1  data-buffer direction controls.
TOUT_ERR  out  1  sticky flag: a GRAM timeout has occurred.

Behaviour:
- Definitions:
  - mreq = ~nMREQ & nRFSH.
  - rfsh = ~nMREQ & ~nRFSH.
  - Window w = AD[3:2].
- Window map: map[0..3], BB bits each.
  - Reset value: map[w] = w mod NBANKS.
  - Write: on a rising edge with ~nIORQ & ~nWR & nM1 & IOA==MAP_PORT and wr_seen==0, set map[D[7:6]] <= D[BB-1:0] and wr_seen <= 1.
  - wr_seen clears when nIORQ is high. Exactly one update per I/O cycle.
- Decode, combinational from registered map:
  - IPL mode: windows 0 and 1 drive nROMCS = ~(mreq & ~nRD); no RAS for windows 0/1. Window 2 -> bank 0, window 3 -> bank 1; the map is ignored.
  - All-RAM mode: window w -> bank map[w].
  - Two windows mapped to the same bank is legal.
- nRAS[b]:
  - Low when mreq and the decoded bank equals b.
  - All NBANKS low during rfsh.
  - Otherwise high.
- fastLCSW = nRFSH & ~&nRAS.
- BUFG0 = nRD & (nM1 | nIORQ). BUFGM = nRD | ~nIORQ.
- rcnt, 3 bits:
  - Cleared whenever nMREQ is high, synchronously on the edge, plus on reset.
  - Otherwise increments each rising edge, saturating at 7.
  - rom_hold = ~nROMCS & (rcnt <= ROM_WAIT).
- GRAM state machine, registered, states IDLE / WAITB / GRANT / TOUT:
  - IDLE -> GRANT when mreq & GRAM_SEL & BLANK.
  - IDLE -> WAITB when mreq & GRAM_SEL & ~BLANK.
  - WAITB -> GRANT when BLANK is high.
  - WAITB -> TOUT when GRAM_TIMEOUT>0 and gcnt == GRAM_TIMEOUT-1; TOUT_ERR <= 1 at the same time.
  - Any state -> IDLE when nMREQ is high; this has priority.
  - gcnt increments only in WAITB and clears in every other state.
- GRAM outputs:
  - nCSG = ~(mreq & GRAM_SEL & (BLANK | state==GRANT) & state!=TOUT).
  - Once GRANT is reached, the access completes even if BLANK falls.
  - gram_hold = mreq & GRAM_SEL & ~BLANK & state!=GRANT & state!=TOUT. It is combinational so that WAIT is valid before the T2 falling edge.
- nWAIT = nEXWAIT & ~rom_hold & ~gram_hold.
- TOUT: nCSG stays high and the access is dropped; the CPU is released.
- TOUT_ERR clears only on reset.
- Reset values:
  - state = IDLE; rcnt = gcnt = 0; wr_seen = 0; TOUT_ERR = 0; map = identity.
  - Outputs follow the combinational equations. With bus idle: nRAS all 1, nROMCS = 1, nCSG = 1, nWAIT = 1, fastLCSW = 0.
- Reset asserted mid-wait: state is forced to IDLE and counters cleared. nWAIT still follows the combinational hold terms.

Test Plan:
- Reset, then bus idle (nMREQ = 1) -> nRAS = 4'b1111, nWAIT = 1, nCSG = 1, TOUT_ERR = 0.
- IPL mode, ROM_WAIT = 2, read of 0x1000 -> nROMCS = 0, nWAIT low across 2 sampled T2/Tw falling edges, then high; no nRAS asserted.
- All-RAM mode; OUT (0xB8), 0x43 (window 1 -> bank 3); read 0x5000 -> nRAS[3] = 0, nRAS[1] = 1; read 0x0000 -> nRAS[0] = 0.
- Refresh cycle (nMREQ = 0, nRFSH = 0) -> all nRAS = 0, fastLCSW = 0, nWAIT = 1.
- GRAM_SEL = 1, BLANK = 0 for 5 clocks, then 1 for 1 clock, then 0 -> nWAIT low for 5 clocks; nCSG = 0 from the BLANK rise until nMREQ rises despite the BLANK fall.
- GRAM_TIMEOUT = 8, BLANK held 0 -> nWAIT releases after 8 clocks in WAITB, nCSG stays 1, TOUT_ERR = 1 until nRST pulses low.
